// File: rtl/jogo_memoria_leitor.sv
// Hex memory game: player one records 4 hex digits, shown for SHOW_CYCLES, then hidden;
// player two re-enters them and the block scores hits. All outputs registered from next-state values.
module jogo_memoria_leitor #(
   parameter int SHOW_CYCLES = 50
) (
   input  logic        clk_2,
   input  logic        rst_n,
   input  logic [3:0]  digito,
   input  logic        confirma,
   output logic [63:0] lcd_a,
   output logic [7:0]  SEG,
   output logic [7:0]  LED
);
   localparam int TW = $clog2(SHOW_CYCLES + 1);
   localparam logic [TW-1:0] TLAST = TW'(SHOW_CYCLES - 1);

   typedef enum logic [2:0] {
      GRAVA     = 3'd1,
      MOSTRA    = 3'd2,
      RESPONDE  = 3'd3,
      RESULTADO = 3'd4
   } state_t;

   state_t        state_q, state_d;
   logic [1:0]    idx_q, idx_d;
   logic [15:0]   rec_q, rec_d;
   logic [15:0]   ans_q, ans_d;
   logic [TW-1:0] timer_q, timer_d;
   logic [2:0]    hits_q, hits_d;
   logic          prev_q;
   logic          edge_w;
   logic [3:0]    slot_lo;
   logic [2:0]    hits_calc;
   logic [63:0]   lcd_d;
   logic [7:0]    seg_d, led_d;

   assign edge_w  = confirma & ~prev_q;
   // Digit 0 sits in the most significant nibble.
   assign slot_lo = 4'd12 - {idx_q, 2'b00};

   always_comb begin
      hits_calc = 3'd0;
      for (int k = 1; k < 4; k++) begin
         if (ans_q[4*k +: 4] == rec_q[4*k +: 4]) hits_calc = hits_calc + 3'd1;
      end
      if (digito == rec_q[3:0]) hits_calc = hits_calc + 3'd1;
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      rec_d   = rec_q;
      ans_d   = ans_q;
      timer_d = timer_q;
      hits_d  = hits_q;
      case (state_q)
         GRAVA: begin
            if (edge_w) begin
               rec_d[slot_lo +: 4] = digito;
               if (idx_q == 2'd3) begin
                  idx_d   = 2'd0;
                  timer_d = '0;
                  state_d = MOSTRA;
               end else begin
                  idx_d = idx_q + 2'd1;
               end
            end
         end
         MOSTRA: begin
            if (timer_q == TLAST) state_d = RESPONDE;
            else                  timer_d = timer_q + TW'(1);
         end
         RESPONDE: begin
            if (edge_w) begin
               ans_d[slot_lo +: 4] = digito;
               if (idx_q == 2'd3) begin
                  idx_d   = 2'd0;
                  hits_d  = hits_calc;
                  state_d = RESULTADO;
               end else begin
                  idx_d = idx_q + 2'd1;
               end
            end
         end
         RESULTADO: begin
            if (edge_w) begin
               rec_d   = '0;
               ans_d   = '0;
               idx_d   = 2'd0;
               hits_d  = 3'd0;
               state_d = GRAVA;
            end
         end
         default: state_d = GRAVA;
      endcase
   end

   always_comb begin
      lcd_d = '0;
      seg_d = 8'h00;
      led_d = {state_d, 5'b00000};
      case (state_d)
         GRAVA: begin
            lcd_d[15:0] = rec_d;
            led_d[2:0]  = {1'b0, idx_d};
         end
         MOSTRA: begin
            lcd_d[15:0] = rec_d;
            led_d[2:0]  = 3'd4;
         end
         RESPONDE: begin
            lcd_d[31:16] = ans_d;
            led_d[2:0]   = {1'b0, idx_d};
         end
         RESULTADO: begin
            lcd_d[34:0] = {hits_d, ans_d, rec_d};
            seg_d       = (hits_d == 3'd4) ? 8'hFF : 8'h80;
            led_d[2:0]  = 3'd4;
         end
         default: led_d = 8'h00;
      endcase
   end

   always_ff @(posedge clk_2 or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= GRAVA;
         idx_q   <= 2'd0;
         rec_q   <= '0;
         ans_q   <= '0;
         timer_q <= '0;
         hits_q  <= 3'd0;
         prev_q  <= 1'b1;
         lcd_a   <= '0;
         SEG     <= 8'h00;
         LED     <= 8'h00;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         rec_q   <= rec_d;
         ans_q   <= ans_d;
         timer_q <= timer_d;
         hits_q  <= hits_d;
         prev_q  <= confirma;
         lcd_a   <= lcd_d;
         SEG     <= seg_d;
         LED     <= led_d;
      end
   end
endmodule

// File: tb/tb_jogo_memoria_leitor.sv
// Directed bench for jogo_memoria_leitor with SHOW_CYCLES=8; outputs sampled on falling edges.
module tb_jogo_memoria_leitor;
   logic        clk_2 = 1'b0;
   logic        rst_n;
   logic [3:0]  digito;
   logic        confirma;
   logic [63:0] lcd_a;
   logic [7:0]  SEG;
   logic [7:0]  LED;
   int          checks = 0;
   int          errors = 0;

   jogo_memoria_leitor #(.SHOW_CYCLES(8)) dut (
      .clk_2   (clk_2),
      .rst_n   (rst_n),
      .digito  (digito),
      .confirma(confirma),
      .lcd_a   (lcd_a),
      .SEG     (SEG),
      .LED     (LED)
   );

   always #5 clk_2 = ~clk_2;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Called just after a falling edge; returns four falling edges later (2 high, 2 low).
   task automatic pulse(input logic [3:0] d);
      digito   = d;
      confirma = 1'b1;
      repeat (2) @(negedge clk_2);
      confirma = 1'b0;
      repeat (2) @(negedge clk_2);
   endtask

   // One cycle high, one cycle low.
   task automatic short_pulse(input logic [3:0] d);
      digito   = d;
      confirma = 1'b1;
      @(negedge clk_2);
      confirma = 1'b0;
      @(negedge clk_2);
   endtask

   initial begin
      rst_n    = 1'b1;
      digito   = 4'h0;
      confirma = 1'b1;
      #2 rst_n = 1'b0;
      #1;
      chk("reset_lcd", lcd_a, 64'h0);
      chk("reset_seg", {56'h0, SEG}, 64'h0);
      chk("reset_led", {56'h0, LED}, 64'h0);
      repeat (2) @(negedge clk_2);
      rst_n = 1'b1;
      repeat (5) @(negedge clk_2);
      chk("held_led", {56'h0, LED}, 64'h20);
      chk("held_lcd", lcd_a, 64'h0);
      confirma = 1'b0;
      @(negedge clk_2);

      // Round 1: record A3F0, check exact show window, answer correctly.
      pulse(4'hA);
      chk("rec1_led", {56'h0, LED}, 64'h21);
      chk("rec1_lcd", lcd_a, 64'hA000);
      pulse(4'h3);
      pulse(4'hF);
      chk("rec3_lcd", lcd_a, 64'hA3F0);
      chk("rec3_led", {56'h0, LED}, 64'h23);
      pulse(4'h0);
      chk("mostra_lcd", lcd_a, 64'hA3F0);
      chk("mostra_led", {56'h0, LED}, 64'h44);
      repeat (4) @(negedge clk_2);
      chk("mostra_last_led", {56'h0, LED}, 64'h44);
      chk("mostra_last_lcd", lcd_a, 64'hA3F0);
      @(negedge clk_2);
      chk("responde_led", {56'h0, LED}, 64'h60);
      chk("responde_lcd", lcd_a, 64'h0);
      pulse(4'hA);
      chk("ans1_lcd", lcd_a, 64'hA000_0000);
      chk("ans1_led", {56'h0, LED}, 64'h61);
      pulse(4'h3);
      pulse(4'hF);
      pulse(4'h0);
      chk("win_seg", {56'h0, SEG}, 64'hFF);
      chk("win_lcd", lcd_a, 64'h4_A3F0_A3F0);
      chk("win_led", {56'h0, LED}, 64'h84);
      pulse(4'h5);
      chk("back_seg", {56'h0, SEG}, 64'h0);
      chk("back_lcd", lcd_a, 64'h0);
      chk("back_led", {56'h0, LED}, 64'h20);

      // Round 2: pulses during the show window (last one on the timeout cycle) are ignored.
      pulse(4'hA);
      pulse(4'h3);
      pulse(4'hF);
      pulse(4'h0);
      short_pulse(4'h1);
      short_pulse(4'h2);
      short_pulse(4'h3);
      chk("ignored_led", {56'h0, LED}, 64'h60);
      chk("ignored_lcd", lcd_a, 64'h0);
      pulse(4'hA);
      pulse(4'h3);
      pulse(4'hE);
      pulse(4'h1);
      chk("lose_seg", {56'h0, SEG}, 64'h80);
      chk("lose_lcd", lcd_a, 64'h2_A3E1_A3F0);
      pulse(4'h9);
      chk("back2_seg", {56'h0, SEG}, 64'h0);
      chk("back2_lcd", lcd_a, 64'h0);

      // Round 3: reset in the middle of answering.
      pulse(4'h1);
      pulse(4'h2);
      pulse(4'h3);
      pulse(4'h4);
      repeat (5) @(negedge clk_2);
      pulse(4'h5);
      pulse(4'h6);
      chk("mid_led", {56'h0, LED}, 64'h62);
      chk("mid_lcd", lcd_a, 64'h5600_0000);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_lcd", lcd_a, 64'h0);
      chk("arst_led", {56'h0, LED}, 64'h0);
      @(negedge clk_2);
      rst_n = 1'b1;
      @(negedge clk_2);
      chk("post_led", {56'h0, LED}, 64'h20);
      chk("post_lcd", lcd_a, 64'h0);
      pulse(4'h7);
      chk("post_rec_lcd", lcd_a, 64'h7000);
      chk("post_rec_led", {56'h0, LED}, 64'h21);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
